non_restoring_divider: RTL and testbench



---
 rtl/non_restoring_divider.sv | 133 +++++++++++++
 tb/tb_non_restoring_divider.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/non_restoring_divider.sv
// rtl/non_restoring_divider.sv - sequential signed divider, one quotient bit per clock
module non_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_FIX    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH+1:0] p;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] dividend_r;
  logic [WIDTH-1:0] divisor_r;

  logic [WIDTH-1:0] dividend_abs;
  logic [WIDTH-1:0] divisor_abs;
  logic [WIDTH+1:0] b_ext;
  logic [WIDTH+1:0] p_shift;
  logic [WIDTH+1:0] p_step;
  logic [WIDTH+1:0] p_fixed;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;
  logic             is_zero;
  logic             is_ovf;
  logic             unused_bits;

  // Magnitude of the most-negative value wraps to 2^(WIDTH-1), which is correct unsigned.
  assign dividend_abs = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign divisor_abs  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

  assign b_ext   = {2'b00, b_mag};
  assign p_shift = {p[WIDTH:0], a_shift[WIDTH-1]};
  assign p_step  = p[WIDTH+1] ? (p_shift + b_ext) : (p_shift - b_ext);
  assign p_fixed = p[WIDTH+1] ? (p + b_ext) : p;
  assign r_mag   = p_fixed[WIDTH-1:0];
  assign unused_bits = ^p_fixed[WIDTH+1:WIDTH];

  assign q_final = (dividend_r[WIDTH-1] ^ divisor_r[WIDTH-1]) ? (~q_mag + 1'b1) : q_mag;
  assign r_final = dividend_r[WIDTH-1] ? (~r_mag + 1'b1) : r_mag;
  assign is_zero = (divisor_r == '0);
  assign is_ovf  = (dividend_r == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor_r == '1);

  // busy and done are registered from the state, so both trail it by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      count       <= '0;
      p           <= '0;
      a_shift     <= '0;
      b_mag       <= '0;
      q_mag       <= '0;
      dividend_r  <= '0;
      divisor_r   <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      busy <= (state == S_DIVIDE) || (state == S_FIX);
      done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start && !done) begin
            dividend_r <= dividend;
            divisor_r  <= divisor;
            a_shift    <= dividend_abs;
            b_mag      <= divisor_abs;
            q_mag      <= '0;
            p          <= '0;
            count      <= CW'(WIDTH);
            state      <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          p       <= p_step;
          q_mag   <= {q_mag[WIDTH-2:0], ~p_step[WIDTH+1]};
          a_shift <= {a_shift[WIDTH-2:0], 1'b0};
          count   <= count - 1'b1;
          if (count == CW'(1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (is_zero) begin
            quotient    <= '1;
            remainder   <= dividend_r;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else if (is_ovf) begin
            quotient    <= {1'b0, {(WIDTH-1){1'b1}}};
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
          end else begin
            quotient    <= q_final;
            remainder   <= r_final;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_non_restoring_divider.sv
// tb/tb_non_restoring_divider.sv - scoreboard bench for non_restoring_divider
module tb_non_restoring_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic       overflow;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
    int         k;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  non_restoring_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ai, bi;
    ai = int'($signed(a));
    bi = int'($signed(b));
    e.a = a; e.b = b; e.dz = 1'b0; e.ov = 1'b0; e.k = 0;
    if (bi == 0) begin
      e.q = 8'hFF; e.r = a; e.dz = 1'b1;
    end else if (ai == -128 && bi == -1) begin
      e.q = 8'd127; e.r = 8'd0; e.ov = 1'b1;
    end else begin
      e.q = 8'(ai / bi);
      e.r = 8'(ai % bi);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) busy_cnt = 0;
    else if (busy) busy_cnt++;
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(mon_e.q));
        chk("remainder", 32'(remainder), 32'(mon_e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.dz));
        chk("overflow", 32'(overflow), 32'(mon_e.ov));
        chk("latency", 32'(cyc - mon_e.k), 32'd10);
        chk("busy_cycles", 32'(busy_cnt), 32'd9);
        if (!mon_e.dz && !mon_e.ov) begin
          chk("invariant",
              32'(int'($signed(quotient)) * int'($signed(mon_e.b)) + int'($signed(remainder))),
              32'(int'($signed(mon_e.a))));
          chk("rem_bound",
              32'((int'($signed(remainder)) < 0 ? -int'($signed(remainder)) : int'($signed(remainder)))
                  < (int'($signed(mon_e.b)) < 0 ? -int'($signed(mon_e.b)) : int'($signed(mon_e.b)))),
              32'd1);
        end
      end
      busy_cnt = 0;
    end
  end

  task automatic wait_done(input bit poke_done);
    int n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      if (poke_done) begin
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
      end
      @(negedge clk);
      start = 1'b0;
      chk("done_pulse", 32'(done), 32'd0);
      if (poke_done) begin
        repeat (14) @(negedge clk);
        chk("ignored_in_done", 32'(busy), 32'd0);
      end
    end
  endtask

  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input bit poke);
    exp_t e;
    dividend = a; divisor = b; start = 1'b1;
    e = model(a, b);
    e.k = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    dividend = 8'($urandom); divisor = 8'($urandom);
    if (poke) begin
      repeat (2) @(negedge clk);
      start = 1'b1; dividend = 8'd1; divisor = 8'd1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(poke);
  endtask

  int sa[] = '{100, -100, 100, -100, -45, 45, 127, 45, -128, 0, 7, 50, -128, 10};
  int sd[] = '{5, 5, -5, -5, 7, -7, 3, 7, 2, 10, 9, 0, -1, 3};
  int edge_v[] = '{-128, -127, -1, 0, 1, 2, 126, 127};

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    chk("rst_ov", 32'(overflow), 32'd0);
    @(negedge clk);

    for (int i = 0; i < sa.size(); i++) run_div(8'(sa[i]), 8'(sd[i]), 1'b0);

    run_div(8'd77, 8'd4, 1'b1);

    dividend = 8'd100; divisor = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (15) @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);

    for (int i = 0; i < edge_v.size(); i++)
      for (int j = 0; j < edge_v.size(); j++)
        run_div(8'(edge_v[i]), 8'(edge_v[j]), 1'b0);

    for (int i = 0; i < 1500; i++) run_div(8'($urandom), 8'($urandom), 1'b0);

    repeat (15) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
